// File: rtl/led_fault_pkg.sv
// Shared definitions for the LED driver fault front end: channel FSM encoding,
// debounce counter sizing and default timing parameters.
package led_fault_pkg;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_IDLE    = 2'd0;
    localparam chan_state_t ST_BLANK   = 2'd1;
    localparam chan_state_t ST_MONITOR = 2'd2;

    localparam int DEF_DEB_CNT   = 8;
    localparam int DEF_BLANK_CYC = 4;

    // Counter must be able to hold the value DEB_CNT itself (saturation point).
    function automatic int deb_w(input int deb_cnt);
        return (deb_cnt < 1) ? 1 : $clog2(deb_cnt + 1);
    endfunction

endpackage

// File: rtl/fault_chan_mon.sv
// One LED channel: on/blank/monitor FSM driven by the channel's pwm bit, plus
// debounced sticky short/open latches that only sample while monitoring.
module fault_chan_mon
    import led_fault_pkg::*;
#(
    parameter int DEB_CNT   = DEF_DEB_CNT,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic sys_clk,
    input  logic sys_resetb,
    input  logic pwm,
    input  logic s_short,
    input  logic s_open,
    input  logic clr,
    output logic short_flt,
    output logic open_flt
);

    localparam int DW = deb_w(DEB_CNT);
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    chan_state_t          state_q;
    logic [BW-1:0]        blank_cnt;
    logic                 qual;
    logic [1:0]           flag_s;
    logic [1:0]           latch_q;
    logic [1:0][DW-1:0]   deb_cnt;

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            state_q   <= ST_IDLE;
            blank_cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pwm) begin
                        state_q   <= (BLANK_CYC == 0) ? ST_MONITOR : ST_BLANK;
                        blank_cnt <= '0;
                    end
                end
                ST_BLANK: begin
                    if (!pwm)
                        state_q <= ST_IDLE;
                    else if (blank_cnt == BLANK_LAST)
                        state_q <= ST_MONITOR;
                    else
                        blank_cnt <= blank_cnt + 1'b1;
                end
                ST_MONITOR: begin
                    if (!pwm)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign qual   = (state_q == ST_MONITOR) && pwm;
    assign flag_s = {s_open, s_short};

    // A set on the same edge as clr takes priority so a fault is never lost.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            deb_cnt <= '0;
            latch_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (qual && flag_s[i] && deb_cnt[i] == DEB_LAST) begin
                    latch_q[i] <= 1'b1;
                    deb_cnt[i] <= DEB_MAX;
                end else if (clr) begin
                    latch_q[i] <= 1'b0;
                    deb_cnt[i] <= '0;
                end else if (qual) begin
                    if (!flag_s[i])
                        deb_cnt[i] <= '0;
                    else if (deb_cnt[i] != DEB_MAX)
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign short_flt = latch_q[0];
    assign open_flt  = latch_q[1];

endmodule

// File: rtl/led_fault_monitor.sv
// Fault front end for one 6-channel LED driver: synchronises raw comparator
// flags, debounces global flags, and hosts one channel monitor per pwm bit.
module led_fault_monitor
    import led_fault_pkg::*;
#(
    parameter int NCH       = 6,
    parameter int DEB_CNT   = DEF_DEB_CNT,
    parameter int BLANK_CYC = DEF_BLANK_CYC,
    parameter int SYNC_STG  = 2
) (
    input  logic           sys_clk,
    input  logic           sys_resetb,
    input  logic [NCH-1:0] pwm_i,
    input  logic [NCH-1:0] short_raw_i,
    input  logic [NCH-1:0] open_raw_i,
    input  logic           ot_raw_i,
    input  logic           ov_raw_i,
    input  logic           uv_raw_i,
    input  logic           clr_i,
    output logic [NCH-1:0] short_o,
    output logic [NCH-1:0] open_o,
    output logic           overheat_o,
    output logic           overvoltage_o,
    output logic           undervoltage_o,
    output logic           fault_any_o
);

    localparam int RAW_W = 2 * NCH + 3;
    localparam int DW    = deb_w(DEB_CNT);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic [RAW_W-1:0]                raw;
    logic [SYNC_STG-1:0][RAW_W-1:0]  sync_q;
    logic [RAW_W-1:0]                sync_s;
    logic [NCH-1:0]                  s_short;
    logic [NCH-1:0]                  s_open;
    logic [2:0]                      s_glb;
    logic [2:0]                      glb_q;
    logic [2:0][DW-1:0]              glb_cnt;

    // Every raw bit, including the channel flags, goes through the same chain.
    assign raw = {uv_raw_i, ov_raw_i, ot_raw_i, open_raw_i, short_raw_i};

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STG-2:0], raw};
    end

    assign sync_s  = sync_q[SYNC_STG-1];
    assign s_short = sync_s[NCH-1:0];
    assign s_open  = sync_s[2*NCH-1:NCH];
    assign s_glb   = sync_s[RAW_W-1:2*NCH];

    // Global flags: bit 0 overtemp, 1 overvoltage, 2 undervoltage; always qualified.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            glb_cnt <= '0;
            glb_q   <= '0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (s_glb[g] && glb_cnt[g] == DEB_LAST) begin
                    glb_q[g]   <= 1'b1;
                    glb_cnt[g] <= DEB_MAX;
                end else if (clr_i) begin
                    glb_q[g]   <= 1'b0;
                    glb_cnt[g] <= '0;
                end else if (!s_glb[g]) begin
                    glb_cnt[g] <= '0;
                end else if (glb_cnt[g] != DEB_MAX) begin
                    glb_cnt[g] <= glb_cnt[g] + 1'b1;
                end
            end
        end
    end

    assign overheat_o     = glb_q[0];
    assign overvoltage_o  = glb_q[1];
    assign undervoltage_o = glb_q[2];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        fault_chan_mon #(
            .DEB_CNT   (DEB_CNT),
            .BLANK_CYC (BLANK_CYC)
        ) u_chan (
            .sys_clk    (sys_clk),
            .sys_resetb (sys_resetb),
            .pwm        (pwm_i[c]),
            .s_short    (s_short[c]),
            .s_open     (s_open[c]),
            .clr        (clr_i),
            .short_flt  (short_o[c]),
            .open_flt   (open_o[c])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb)
            fault_any_o <= 1'b0;
        else
            fault_any_o <= |{short_o, open_o, glb_q};
    end

endmodule

// File: tb/tb_led_fault_monitor.sv
// Bench for led_fault_monitor: vector table plus hand sequences for blanking,
// debounce restart, clear priority and async reset; expectations queued per step.
module tb_led_fault_monitor;

    typedef struct packed {
        logic [5:0] sh;
        logic [5:0] op;
        logic       ot;
        logic       ov;
        logic       uv;
        logic       any;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [5:0] pwm;
        logic [5:0] sh;
        logic [5:0] op;
        logic       ot;
        logic       ov;
        logic       uv;
        logic       clr;
        int         n;
        obs_t       exp;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       sys_resetb = 1'b0;
    logic [5:0] pwm_i = '0, short_raw_i = '0, open_raw_i = '0;
    logic       ot_raw_i = 1'b0, ov_raw_i = 1'b0, uv_raw_i = 1'b0, clr_i = 1'b0;
    logic [5:0] short_o, open_o;
    logic       overheat_o, overvoltage_o, undervoltage_o, fault_any_o;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_run = 0, n_fail = 0;
    vec_t  vecs[17];

    always #5 sys_clk = ~sys_clk;

    led_fault_monitor dut (
        .sys_clk        (sys_clk),
        .sys_resetb     (sys_resetb),
        .pwm_i          (pwm_i),
        .short_raw_i    (short_raw_i),
        .open_raw_i     (open_raw_i),
        .ot_raw_i       (ot_raw_i),
        .ov_raw_i       (ov_raw_i),
        .uv_raw_i       (uv_raw_i),
        .clr_i          (clr_i),
        .short_o        (short_o),
        .open_o         (open_o),
        .overheat_o     (overheat_o),
        .overvoltage_o  (overvoltage_o),
        .undervoltage_o (undervoltage_o),
        .fault_any_o    (fault_any_o)
    );

    function automatic obs_t ob(logic [5:0] sh, logic [5:0] op, logic ot, logic ov,
                                logic uv, logic any);
        obs_t o;
        o = '{sh: sh, op: op, ot: ot, ov: ov, uv: uv, any: any};
        return o;
    endfunction

    function automatic vec_t mkv(logic rst, logic [5:0] pwm, logic [5:0] sh, logic [5:0] op,
                                 logic ot, logic ov, logic uv, logic clr, int n, obs_t e);
        vec_t v;
        v.rst = rst; v.pwm = pwm; v.sh = sh; v.op = op;
        v.ot = ot; v.ov = ov; v.uv = uv; v.clr = clr; v.n = n; v.exp = e;
        return v;
    endfunction

    function automatic obs_t act();
        return {short_o, open_o, overheat_o, overvoltage_o, undervoltage_o, fault_any_o};
    endfunction

    task automatic drive(logic [5:0] pwm, logic [5:0] sh, logic [5:0] op,
                         logic ot, logic ov, logic uv, logic clr);
        pwm_i = pwm; short_raw_i = sh; open_raw_i = op;
        ot_raw_i = ot; ov_raw_i = ov; uv_raw_i = uv; clr_i = clr;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_front();
        obs_t  e, a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = act();
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got sh=%h op=%h ot=%b ov=%b uv=%b any=%b, want sh=%h op=%h ot=%b ov=%b uv=%b any=%b",
                     t, a.sh, a.op, a.ot, a.ov, a.uv, a.any, e.sh, e.op, e.ot, e.ov, e.uv, e.any);
        end
    endtask

    task automatic expect_after(int n, obs_t e, string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        step(n);
        check_front();
    endtask

    task automatic do_reset();
        sys_resetb = 1'b0;
        step(2);
        sys_resetb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with everything asserted, then staged latch times.
        vecs[0]  = mkv(1, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 9, ob(0, 0, 0, 0, 0, 0));
        vecs[1]  = mkv(0, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 1, ob(0, 0, 1, 1, 1, 0));
        vecs[2]  = mkv(0, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 1, ob(0, 0, 1, 1, 1, 1));
        vecs[3]  = mkv(0, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 1, ob(0, 0, 1, 1, 1, 1));
        vecs[4]  = mkv(0, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 1, ob(6'h3F, 6'h3F, 1, 1, 1, 1));
        // Reset mid-debounce must leave no partial count behind.
        vecs[5]  = mkv(1, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 5, ob(0, 0, 0, 0, 0, 0));
        vecs[6]  = mkv(1, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 9, ob(0, 0, 0, 0, 0, 0));
        vecs[7]  = mkv(0, 6'h3F, 6'h3F, 6'h3F, 1, 1, 1, 0, 1, ob(0, 0, 1, 1, 1, 0));
        // pwm gating on channel 3.
        vecs[8]  = mkv(1, 6'h00, 6'h08, 6'h00, 0, 0, 0, 0, 100, ob(0, 0, 0, 0, 0, 0));
        vecs[9]  = mkv(0, 6'h08, 6'h08, 6'h00, 0, 0, 0, 0, 12, ob(0, 0, 0, 0, 0, 0));
        vecs[10] = mkv(0, 6'h08, 6'h08, 6'h00, 0, 0, 0, 0, 1, ob(6'h08, 0, 0, 0, 0, 0));
        vecs[11] = mkv(0, 6'h08, 6'h08, 6'h00, 0, 0, 0, 0, 1, ob(6'h08, 0, 0, 0, 0, 1));
        // Aggregate with only undervoltage, then cleared.
        vecs[12] = mkv(1, 6'h00, 6'h00, 6'h00, 0, 0, 1, 0, 10, ob(0, 0, 0, 0, 1, 0));
        vecs[13] = mkv(0, 6'h00, 6'h00, 6'h00, 0, 0, 1, 0, 1, ob(0, 0, 0, 0, 1, 1));
        vecs[14] = mkv(0, 6'h00, 6'h00, 6'h00, 0, 0, 0, 0, 3, ob(0, 0, 0, 0, 1, 1));
        vecs[15] = mkv(0, 6'h00, 6'h00, 6'h00, 0, 0, 0, 1, 1, ob(0, 0, 0, 0, 0, 1));
        vecs[16] = mkv(0, 6'h00, 6'h00, 6'h00, 0, 0, 0, 0, 1, ob(0, 0, 0, 0, 0, 0));

        @(negedge sys_clk);
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pwm, vecs[i].sh, vecs[i].op, vecs[i].ot, vecs[i].ov,
                  vecs[i].uv, vecs[i].clr);
            if (vecs[i].rst)
                do_reset();
            expect_after(vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Short pulse confined to the blank window is ignored; a steady flag is not.
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(6'h01, 6'h01, 0, 0, 0, 0, 0);
        step(4);
        drive(6'h01, 6'h00, 0, 0, 0, 0, 0);
        expect_after(30, ob(0, 0, 0, 0, 0, 0), "blank_pulse");
        drive(6'h01, 6'h01, 0, 0, 0, 0, 0);
        expect_after(9, ob(0, 0, 0, 0, 0, 0), "blank_pre");
        expect_after(1, ob(6'h01, 0, 0, 0, 0, 0), "blank_set");
        expect_after(1, ob(6'h01, 0, 0, 0, 0, 1), "blank_any");

        // A single low sample restarts the debounce count.
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(6'h04, 0, 0, 0, 0, 0, 0);
        step(6);
        drive(6'h04, 0, 6'h04, 0, 0, 0, 0);
        step(7);
        drive(6'h04, 0, 6'h00, 0, 0, 0, 0);
        expect_after(1, ob(0, 0, 0, 0, 0, 0), "deb_gap");
        drive(6'h04, 0, 6'h04, 0, 0, 0, 0);
        expect_after(9, ob(0, 0, 0, 0, 0, 0), "deb_run9");
        expect_after(1, ob(0, 6'h04, 0, 0, 0, 0), "deb_latch");

        // Clear behaviour: plain clear, clear colliding with set, re-latch.
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_after(10, ob(0, 0, 0, 1, 0, 0), "ov_set");
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_after(3, ob(0, 0, 0, 1, 0, 1), "ov_sticky");
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_after(1, ob(0, 0, 0, 0, 0, 1), "clr_ov");
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_after(1, ob(0, 0, 0, 0, 0, 0), "clr_any");
        drive(0, 0, 0, 0, 0, 1, 0);
        expect_after(9, ob(0, 0, 0, 0, 0, 0), "uv_pre");
        drive(0, 0, 0, 0, 0, 1, 1);
        expect_after(1, ob(0, 0, 0, 0, 1, 0), "clr_set_win");
        drive(0, 0, 0, 0, 0, 1, 0);
        expect_after(1, ob(0, 0, 0, 0, 1, 1), "uv_held");
        drive(0, 0, 0, 0, 0, 1, 1);
        expect_after(1, ob(0, 0, 0, 0, 0, 1), "clr_uv");
        drive(0, 0, 0, 0, 0, 1, 0);
        expect_after(7, ob(0, 0, 0, 0, 0, 0), "relatch_pre");
        expect_after(1, ob(0, 0, 0, 0, 1, 0), "relatch");

        // Asynchronous reset clears latched state without a clock edge.
        sys_resetb = 1'b0;
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 0));
        tag_q.push_back("async_rst");
        check_front();
        step(1);
        sys_resetb = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
